prbs31_burst_ctrl: RTL and testbench
====================================

Name: prbs31_burst_ctrl

Overview:
Sequences a PRBS31 generator (x^31 + x^28 + 1) to emit bursts of a programmed length.
- Handles start/stop, seeding, and a one-cycle done indication.
- Supports single-bit error injection and keeps a count of injected errors.
- Sits between the top-level pin wrapper (ui_in/uo_out mapping) and the PRBS31 LFSR datapath.

Parameters:
LEN_W, 8, width of burst length and bits-remaining counter
ERRC_W, 8, width of saturating injected-error counter
DEF_SEED, 31'h7FFF_FFFF, seed substituted when seed_in is zero

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-high (rst_n=1 resets)
start  in  1  begin burst (level-sampled in IDLE)
stop  in  1  abort current burst
len  in  LEN_W  burst length in bits, sampled on accepted start
seed_in  in  31  LFSR seed, sampled on accepted start
inj_err  in  1  request inversion of the next emitted bit
bit_out  out  1  PRBS bit (lfsr[30] XOR pending error)
valid  out  1  bit_out is a burst bit this cycle
busy  out  1  state == RUN
done  out  1  one-cycle pulse on normal burst completion
bits_left  out  LEN_W  remaining bits including current
err_count  out  ERRC_W  injected errors applied, saturating

Behaviour:
- Reset (rst_n=1, async), all values held while asserted:
  - state=IDLE; lfsr=DEF_SEED; cnt=0; pending=0; err_count=0.
  - Outputs: valid=0, busy=0, done=0, bits_left=0, bit_out=0.
- States: IDLE, RUN, DONE. The state register is the only FSM storage.
- IDLE:
  - start=1 and len!=0: next edge loads lfsr=(seed_in==0 ? DEF_SEED : seed_in), cnt=len, state=RUN.
  - start=1 and len==0: ignored, stays IDLE.
- RUN:
  - valid=1, busy=1, bits_left=cnt, bit_out=lfsr[30]^pending. All of these are combinational from registers.
  - Each edge: lfsr <= {lfsr[29:0], lfsr[30]^lfsr[27]}; cnt <= cnt-1.
  - cnt==1 and stop=0: next state DONE, cnt becomes 0.
  - stop=1: current bit is still valid; next state IDLE, cnt cleared, no done pulse. stop has priority over terminal count.
- DONE: done=1, valid=0, for exactly one cycle, then IDLE. start is ignored in DONE.
- Latency: first valid bit appears 1 cycle after start is sampled. Back-to-back bursts have a minimum gap of 2 cycles (DONE, IDLE).
- Error injection:
  - inj_err sets pending on the next edge in any state.
  - The pending bit inverts the first valid bit seen while pending=1; pending clears on that edge and err_count increments.
  - err_count saturates at all-ones.
  - inj_err in the same cycle as a valid bit affects the following bit.
  - Multiple inj_err pulses before consumption collapse into one.
  - pending survives stop and burst boundaries.
- LFSR holds its value in IDLE and DONE; it never reaches all-zero.
- Outside RUN, bits_left=0 and bit_out=0.

Decomposition:
- Package prbs_pkg:
  - state enum {IDLE, RUN, DONE};
  - PRBS31_TAP_HI=30, PRBS31_TAP_LO=27;
  - DEF_SEED constant.
- Sub-module prbs31_lfsr (clk, rst_n, load, en, seed[30:0], q[30:0]) holds the shift register.
- The controller owns the FSM, counter, injection logic and zero-seed substitution.

Test Plan:
- seed_in=31'h7FFF_FFFF, len=40, start pulse: valid high for exactly 40 cycles; bits are 31 ones then 9 zeros; done high 1 cycle after last bit; bits_left steps 40..1.
- seed_in=0, len=40: identical bit stream to the previous test (DEF_SEED substituted).
- len=100, stop asserted in cycle 10 of RUN: 10 valid bits, then IDLE; no done pulse; bits_left=0.
- inj_err pulsed in IDLE, then burst with seed all-ones, len=4: bits are 0,1,1,1; err_count=1; pending=0 afterwards.
- len=0 with start held 5 cycles: no valid, busy, or done activity. start held through DONE: a new burst begins only after the IDLE cycle.
- rst_n=1 mid-burst (cycle 5 of len=20): outputs go to reset values immediately without waiting for a clock edge. After release, a new start with seed all-ones restarts the stream at the 31-ones prefix.

Source files
------------

// File: rtl/prbs_pkg.sv
// prbs_pkg: shared state encoding, PRBS31 tap positions and default seed
package prbs_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int PRBS31_TAP_HI = 30;
  localparam int PRBS31_TAP_LO = 27;
  localparam logic [30:0] DEF_SEED = 31'h7FFF_FFFF;
endpackage

// File: rtl/prbs31_lfsr.sv
// prbs31_lfsr: x^31 + x^28 + 1 shift register with seed load and shift enable
module prbs31_lfsr import prbs_pkg::*; #(
  parameter logic [30:0] RST_SEED = prbs_pkg::DEF_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        en,
  input  logic [30:0] seed,
  output logic [30:0] q
);
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) q <= RST_SEED;
    else if (load) q <= seed;
    else if (en) q <= {q[29:0], q[PRBS31_TAP_HI] ^ q[PRBS31_TAP_LO]};
endmodule

// File: rtl/prbs31_burst_ctrl.sv
// prbs31_burst_ctrl: sequences PRBS31 bursts with stop, seeding, done pulse and error injection
module prbs31_burst_ctrl #(
  parameter int          LEN_W    = 8,
  parameter int          ERRC_W   = 8,
  parameter logic [30:0] DEF_SEED = 31'h7FFF_FFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stop,
  input  logic [LEN_W-1:0]  len,
  input  logic [30:0]       seed_in,
  input  logic              inj_err,
  output logic              bit_out,
  output logic              valid,
  output logic              busy,
  output logic              done,
  output logic [LEN_W-1:0]  bits_left,
  output logic [ERRC_W-1:0] err_count
);
  import prbs_pkg::*;
  state_t             r_state, w_next;
  logic [LEN_W-1:0]   r_cnt;
  logic               r_pend;
  logic [ERRC_W-1:0]  r_errc;
  logic [30:0]        w_q;
  logic               w_load, w_hit;
  logic [30:0]        w_seed;
  assign w_load    = (r_state == IDLE) && start && (len != '0);
  assign w_hit     = valid && r_pend;
  assign w_seed    = (seed_in == '0) ? DEF_SEED : seed_in;
  assign err_count = r_errc;
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) r_state <= IDLE;
    else r_state <= w_next;
  always_comb
    w_next = (r_state == IDLE) ? (w_load ? RUN : IDLE) :
             (r_state == RUN)  ? (stop ? IDLE : (r_cnt == LEN_W'(1) ? DONE : RUN)) :
                                 IDLE;
  always_comb begin
    valid     = r_state == RUN;
    busy      = r_state == RUN;
    done      = r_state == DONE;
    bits_left = valid ? r_cnt : '0;
    bit_out   = valid & (w_q[PRBS31_TAP_HI] ^ r_pend);
  end
  always_ff @(posedge clk or posedge rst_n)
    if (rst_n) begin
      r_cnt  <= '0;
      r_pend <= 1'b0;
      r_errc <= '0;
    end else begin
      r_cnt  <= w_load ? len : (valid ? (stop ? '0 : r_cnt - LEN_W'(1)) : r_cnt);
      r_pend <= inj_err | (r_pend & ~valid);
      if (w_hit && !(&r_errc)) r_errc <= r_errc + ERRC_W'(1);
    end
  prbs31_lfsr #(.RST_SEED(DEF_SEED)) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (w_load),
    .en    (valid),
    .seed  (w_seed),
    .q     (w_q)
  );
endmodule

// File: tb/tb_prbs31_burst_ctrl.sv
// tb_prbs31_burst_ctrl: scoreboard bench for prbs31_burst_ctrl
module tb_prbs31_burst_ctrl;
  typedef struct {
    bit       d;
    bit       b;
    bit [7:0] left;
  } exp_t;
  logic        clk, rst_n, start, stop, inj_err;
  logic [7:0]  len;
  logic [30:0] seed_in;
  logic        bit_out, valid, busy, done;
  logic [7:0]  bits_left, err_count;
  exp_t        q[$];
  bit          s[0:399];
  int          n_chk = 0;
  int          n_pass = 0;
  prbs31_burst_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .stop      (stop),
    .len       (len),
    .seed_in   (seed_in),
    .inj_err   (inj_err),
    .bit_out   (bit_out),
    .valid     (valid),
    .busy      (busy),
    .done      (done),
    .bits_left (bits_left),
    .err_count (err_count)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic exp_bits(input int n, input int total, input bit inv);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.d = 1'b0;
      e.b = s[i] ^ inv;
      e.left = 8'(total - i);
      q.push_back(e);
    end
  endtask
  task automatic exp_bit(input bit b, input int left);
    exp_t e;
    e.d = 1'b0;
    e.b = b;
    e.left = 8'(left);
    q.push_back(e);
  endtask
  task automatic exp_done;
    exp_t e;
    e.d = 1'b1;
    e.b = 1'b0;
    e.left = 8'd0;
    q.push_back(e);
  endtask
  task automatic go(input int l, input logic [30:0] sd);
    start = 1'b1;
    len = 8'(l);
    seed_in = sd;
    tick;
    start = 1'b0;
  endtask
  task automatic drain(input int max);
    for (int i = 0; i < max && q.size() != 0; i++) @(negedge clk);
    chk("drain", q.size(), 0);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid || done) begin
        if (q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_output: got valid=%b done=%b expected none at %0t", valid, done, $time);
        end else begin
          e = q.pop_front();
          if (e.d) chk("done_pulse", {30'd0, valid, done}, 32'd1);
          else begin
            chk("valid_bit", {30'd0, valid, done}, 32'd2);
            chk("bit_out", bit_out, e.b);
            chk("bits_left", bits_left, e.left);
          end
        end
      end
    end
  end
  initial begin
    bit found;
    rst_n = 1'b1; start = 1'b0; stop = 1'b0; len = '0; seed_in = '0; inj_err = 1'b0;
    for (int i = 0; i < 31; i++) s[i] = 1'b1;
    for (int m = 31; m < 400; m++) s[m] = s[m-31] ^ s[m-28];
    #3;
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_bits_left", bits_left, 0);
    chk("rst_bit_out", bit_out, 0);
    chk("rst_err_count", err_count, 0);
    tick; tick;
    rst_n = 1'b0;
    tick;
    exp_bits(40, 40, 0); exp_done;
    go(40, 31'h7FFF_FFFF);
    drain(60);
    tick;
    exp_bits(40, 40, 0); exp_done;
    go(40, 31'h0);
    drain(60);
    tick;
    exp_bits(10, 100, 0);
    go(100, 31'h7FFF_FFFF);
    repeat (9) tick;
    stop = 1'b1;
    tick;
    stop = 1'b0;
    chk("stop_busy", busy, 0);
    chk("stop_bits_left", bits_left, 0);
    repeat (3) tick;
    drain(5);
    tick;
    inj_err = 1'b1;
    tick;
    inj_err = 1'b0;
    exp_bit(0, 4); exp_bit(1, 3); exp_bit(1, 2); exp_bit(1, 1); exp_done;
    go(4, 31'h7FFF_FFFF);
    drain(10);
    chk("inj_err_count", err_count, 1);
    tick;
    exp_bits(2, 2, 0); exp_done;
    go(2, 31'h7FFF_FFFF);
    drain(10);
    chk("pend_cleared_count", err_count, 1);
    tick;
    start = 1'b1; len = 8'd0; seed_in = 31'h7FFF_FFFF;
    repeat (5) begin
      tick;
      chk("len0_busy", busy, 0);
    end
    exp_bits(3, 3, 0); exp_done; exp_bits(3, 3, 0); exp_done;
    len = 8'd3;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      found = done;
    end
    chk("held_done_seen", found, 1);
    @(negedge clk);
    chk("held_gap_idle", busy, 0);
    @(negedge clk);
    chk("held_restart", busy, 1);
    tick;
    start = 1'b0;
    drain(20);
    tick;
    inj_err = 1'b1;
    tick;
    exp_bits(255, 255, 1); exp_done;
    go(255, 31'h7FFF_FFFF);
    drain(300);
    chk("sat_count", err_count, 255);
    tick;
    inj_err = 1'b0;
    exp_bit(~s[0], 1); exp_done;
    go(1, 31'h7FFF_FFFF);
    drain(10);
    chk("sat_hold", err_count, 255);
    tick;
    exp_bits(4, 20, 0);
    go(20, 31'h7FFF_FFFF);
    repeat (4) tick;
    #1 rst_n = 1'b1;
    #1;
    chk("arst_valid", valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_bits_left", bits_left, 0);
    chk("arst_bit_out", bit_out, 0);
    chk("arst_err_count", err_count, 0);
    tick; tick;
    rst_n = 1'b0;
    tick;
    exp_bits(33, 33, 0); exp_done;
    go(33, 31'h7FFF_FFFF);
    drain(50);
    repeat (3) tick;
    chk("queue_empty", q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
